// File: rtl/pwm_clock_prescaler.sv
// pwm_clock_prescaler
//   Run-time programmable clock prescaler for the PWM datapath. Divides clk
//   by 2*(div+1) into a 50 % duty square wave, emits a one-cycle tick on the
//   first clk cycle of each high phase, and exposes the half-period counter
//   for downstream PWM comparators.
//
//   Optional feature macro: PWM_PRESC_SYNC_EN (adds the sync input).
//
// Ports
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous, active-high reset
//   en         in   1      1 = run, 0 = idle (counter cleared, output low)
//   div        in   WIDTH  half-period minus one; sampled at period boundaries
//   sync       in   1      (PWM_PRESC_SYNC_EN only) restart phase-aligned
//   clk_presc  out  1      divided clock, registered
//   tick       out  1      one-cycle strobe at the start of each high phase
//   phase_cnt  out  WIDTH  current half-period counter, registered
module pwm_clock_prescaler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] div,
`ifdef PWM_PRESC_SYNC_EN
  input  logic             sync,
`endif
  output logic             clk_presc,
  output logic             tick,
  output logic [WIDTH-1:0] phase_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    LOW_PH,
    HIGH_PH
  } state_t;

  // The state is not stored separately: it is fully encoded by en and the
  // registered output, so the output can never disagree with the state.
  state_t state;

  logic [WIDTH-1:0] div_act_reg;
  logic [WIDTH-1:0] div_act_next;
  logic [WIDTH-1:0] phase_next;
  logic             clk_presc_next;
  logic             tick_next;
  logic             terminal;
  logic             restart;

  always_comb begin
    state = IDLE;
    if (en) begin
      state = clk_presc ? HIGH_PH : LOW_PH;
    end
  end

  // Compare against the latched ratio, so div changes mid-period cannot
  // shorten the current half-period.
  assign terminal = (phase_cnt == div_act_reg);

`ifdef PWM_PRESC_SYNC_EN
  // sync only acts while running; idle already performs the same clear.
  assign restart = (state == IDLE) || sync;
`else
  assign restart = (state == IDLE);
`endif

  always_comb begin
    phase_next     = phase_cnt;
    clk_presc_next = clk_presc;
    tick_next      = 1'b0;
    div_act_next   = div_act_reg;
    if (restart) begin
      phase_next     = '0;
      clk_presc_next = 1'b0;
      div_act_next   = div;
    end else begin
      case (state)
        LOW_PH: begin
          if (terminal) begin
            phase_next     = '0;
            clk_presc_next = 1'b1;
            tick_next      = 1'b1;
          end else begin
            phase_next = phase_cnt + 1'b1;
          end
        end
        HIGH_PH: begin
          if (terminal) begin
            // End of a full period: the only point where a new ratio is taken.
            phase_next     = '0;
            clk_presc_next = 1'b0;
            div_act_next   = div;
          end else begin
            phase_next = phase_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_cnt   <= '0;
      clk_presc   <= 1'b0;
      tick        <= 1'b0;
      div_act_reg <= '0;
    end else begin
      phase_cnt   <= phase_next;
      clk_presc   <= clk_presc_next;
      tick        <= tick_next;
      div_act_reg <= div_act_next;
    end
  end

endmodule

// File: tb/tb_pwm_clock_prescaler.sv
// tb_pwm_clock_prescaler
//   Directed bench for pwm_clock_prescaler (WIDTH=8): a per-cycle vector
//   table for the /4 and /2 ratios plus hand-written multi-cycle sequences
//   for async reset, ratio change, maximum ratio, en drop and (when
//   PWM_PRESC_SYNC_EN is defined) the sync restart.
module tb_pwm_clock_prescaler;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [WIDTH-1:0] div;
  logic             clk_presc;
  logic             tick;
  logic [WIDTH-1:0] phase_cnt;
`ifdef PWM_PRESC_SYNC_EN
  logic             sync;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pwm_clock_prescaler #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .div       (div),
`ifdef PWM_PRESC_SYNC_EN
    .sync      (sync),
`endif
    .clk_presc (clk_presc),
    .tick      (tick),
    .phase_cnt (phase_cnt)
  );

  typedef struct {
    logic             en;
    logic [WIDTH-1:0] div;
    logic             exp_clk;
    logic             exp_tick;
    logic [WIDTH-1:0] exp_ph;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until clk_presc equals lvl; returns the number of edges taken.
  task automatic wait_level(input logic lvl, output int edges);
    edges = 0;
    while (clk_presc !== lvl && edges < 2000) begin
      step();
      edges++;
    end
    if (clk_presc !== lvl) chk("wait_level_timeout", 0, 1);
  endtask

  // Called just after clk_presc enters lvl; counts samples spent at lvl.
  task automatic measure(input logic lvl, output int n, output int ticks,
                         output int max_ph);
    n = 0;
    ticks = 0;
    max_ph = 0;
    do begin
      n++;
      if (tick === 1'b1) ticks++;
      if (int'(phase_cnt) > max_ph) max_ph = int'(phase_cnt);
      step();
    end while (clk_presc === lvl && n < 2000);
  endtask

  initial begin
    int e, n, t, m;

    vecs[0]  = '{1'b0, 8'd1, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 8'd1, 1'b0, 1'b0, 8'd1};
    vecs[2]  = '{1'b1, 8'd1, 1'b1, 1'b1, 8'd0};
    vecs[3]  = '{1'b1, 8'd1, 1'b1, 1'b0, 8'd1};
    vecs[4]  = '{1'b1, 8'd1, 1'b0, 1'b0, 8'd0};
    vecs[5]  = '{1'b1, 8'd1, 1'b0, 1'b0, 8'd1};
    vecs[6]  = '{1'b1, 8'd1, 1'b1, 1'b1, 8'd0};
    vecs[7]  = '{1'b1, 8'd0, 1'b1, 1'b0, 8'd1};
    vecs[8]  = '{1'b1, 8'd0, 1'b0, 1'b0, 8'd0};
    vecs[9]  = '{1'b1, 8'd0, 1'b1, 1'b1, 8'd0};
    vecs[10] = '{1'b1, 8'd0, 1'b0, 1'b0, 8'd0};
    vecs[11] = '{1'b1, 8'd0, 1'b1, 1'b1, 8'd0};
    vecs[12] = '{1'b1, 8'd0, 1'b0, 1'b0, 8'd0};

    reset = 1'b1;
    en = 1'b0;
    div = 8'd1;
`ifdef PWM_PRESC_SYNC_EN
    sync = 1'b0;
`endif
    step();
    step();
    chk("reset_clk", clk_presc, 0);
    chk("reset_tick", tick, 0);
    chk("reset_phase", phase_cnt, 0);
    reset = 1'b0;

    // Async reset in the middle of a high phase.
    step();
    en = 1'b1;
    wait_level(1'b1, e);
    chk("pre_reset_high", clk_presc, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_clk", clk_presc, 0);
    chk("async_reset_tick", tick, 0);
    chk("async_reset_phase", phase_cnt, 0);
    en = 1'b0;
    step();
    reset = 1'b0;

    // Table: /4 after reset release, then div=0 taking effect at the boundary.
    for (int i = 0; i < 13; i++) begin
      en = vecs[i].en;
      div = vecs[i].div;
      step();
      $display("[TB] vec %0d en=%0d div=%0d -> clk=%0d tick=%0d ph=%0d", i,
               en, div, clk_presc, tick, phase_cnt);
      chk($sformatf("vec%0d_clk", i), clk_presc, vecs[i].exp_clk);
      chk($sformatf("vec%0d_tick", i), tick, vecs[i].exp_tick);
      chk($sformatf("vec%0d_phase", i), phase_cnt, vecs[i].exp_ph);
    end

    // Ratio change 3 -> 7 during the high phase.
    en = 1'b0;
    div = 8'd3;
    step();
    en = 1'b1;
    wait_level(1'b1, e);
    chk("div3_first_rise", e, 4);
    step();
    div = 8'd7;
    measure(1'b1, n, t, m);
    chk("div_change_rest_high", n, 3);
    measure(1'b0, n, t, m);
    chk("div_change_low", n, 8);
    measure(1'b1, n, t, m);
    chk("div_change_high", n, 8);
    chk("div_change_tick", t, 1);
    $display("[TB] div change 3->7: next half periods 8/8");

    // Maximum ratio.
    en = 1'b0;
    div = 8'd255;
    step();
    en = 1'b1;
    wait_level(1'b1, e);
    chk("div255_first_rise", e, 256);
    measure(1'b1, n, t, m);
    chk("div255_high_len", n, 256);
    chk("div255_high_ticks", t, 1);
    chk("div255_high_maxph", m, 255);
    measure(1'b0, n, t, m);
    chk("div255_low_len", n, 256);
    chk("div255_low_ticks", t, 0);
    chk("div255_low_maxph", m, 255);
    $display("[TB] div=255: period measured");

    // en dropped mid low phase.
    en = 1'b0;
    div = 8'd5;
    step();
    en = 1'b1;
    step();
    step();
    chk("endrop_pre_phase", phase_cnt, 2);
    chk("endrop_pre_clk", clk_presc, 0);
    en = 1'b0;
    step();
    chk("endrop_phase", phase_cnt, 0);
    chk("endrop_clk", clk_presc, 0);
    en = 1'b1;
    wait_level(1'b1, e);
    chk("endrop_rise_edges", e, 6);
    chk("endrop_rise_tick", tick, 1);
    $display("[TB] en drop/re-enable: rise after %0d edges", e);

`ifdef PWM_PRESC_SYNC_EN
    // sync restart during the high phase.
    en = 1'b0;
    div = 8'd4;
    step();
    en = 1'b1;
    wait_level(1'b1, e);
    step();
    step();
    step();
    chk("sync_pre_phase", phase_cnt, 3);
    chk("sync_pre_clk", clk_presc, 1);
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_clk", clk_presc, 0);
    chk("sync_phase", phase_cnt, 0);
    wait_level(1'b1, e);
    chk("sync_rise_edges", e, 5);
    chk("sync_rise_tick", tick, 1);
    en = 1'b0;
    sync = 1'b1;
    step();
    chk("sync_idle_clk", clk_presc, 0);
    chk("sync_idle_phase", phase_cnt, 0);
    sync = 1'b0;
    en = 1'b1;
    wait_level(1'b1, e);
    chk("sync_idle_rise_edges", e, 5);
    $display("[TB] sync restart: rise after %0d edges", e);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
